// File: rtl/rom_mem_bridge.sv
// Bridges the mapper's level-style ROM strobes to a single-outstanding req/ack memory port.
// Define ROM_LAST_WORD_CACHE_EN to add a one-entry last-read-word cache.
module rom_mem_bridge #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [15:0]       ROM_D,
    input  logic              ROM_CE_N,
    input  logic              ROM_OE_N,
    input  logic              ROM_WE_N,
    input  logic              ROM_WORD,
    output logic [15:0]       ROM_Q,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [1:0]        MEM_BE,
    output logic [15:0]       MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_RDATA,
    output logic              BUSY,
    output logic              TIMEOUT_ERR
);
    localparam int unsigned CNT_W = 8;
    localparam bit TMO_EN = (ACK_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic              wr;
        logic              word;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } acc_t;

    function automatic logic [1:0] be_of(input acc_t a);
        return a.word ? 2'b11 : (a.addr[0] ? 2'b10 : 2'b01);
    endfunction

    function automatic logic [15:0] wdata_of(input acc_t a);
        return a.word ? a.data : {a.data[7:0], a.data[7:0]};
    endfunction

    function automatic logic [15:0] read_q(input logic [15:0] d, input logic [1:0] be);
        return (be == 2'b11) ? d : {8'h00, be[1] ? d[15:8] : d[7:0]};
    endfunction

    state_t              state, state_d;
    logic                rd_prev, wr_prev;
    logic                last_vld, last_vld_d, last_word, last_word_d;
    logic [ADDR_W-1:0]   last_addr, last_addr_d;
    logic                pend_vld, pend_vld_d;
    acc_t                pend, pend_d;
    logic [CNT_W-1:0]    tmo_cnt, tmo_cnt_d;
    logic                mem_req_d, mem_we_d, busy_d, tmo_err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [1:0]          mem_be_d;
    logic [15:0]         mem_wdata_d, rom_q_d;
    logic                issue;
    acc_t                issue_acc;

    // Access detection: edges of the qualified strobes plus read address changes
    logic rd_act, wr_act, rd_trig, wr_trig, trig;
    acc_t cur;
    assign rd_act  = ~ROM_CE_N & ~ROM_OE_N;
    assign wr_act  = ~ROM_CE_N & ~ROM_WE_N;
    assign wr_trig = wr_act & ~wr_prev;
    assign rd_trig = rd_act & ~wr_act &
                     (~rd_prev | ~last_vld | ({ROM_ADDR, ROM_WORD} != {last_addr, last_word}));
    assign trig    = rd_trig | wr_trig;
    assign cur     = '{wr: wr_act, word: ROM_WORD, addr: ROM_ADDR, data: ROM_D};

`ifdef ROM_LAST_WORD_CACHE_EN
    logic                cache_vld, cache_vld_d;
    logic [ADDR_W-1:0]   cache_tag, cache_tag_d;
    logic [15:0]         cache_data, cache_data_d;
    logic                hit;
    assign hit = cache_vld && (cache_tag == {ROM_ADDR[ADDR_W-1:1], 1'b0});
`endif

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            rd_prev     <= 1'b0;
            wr_prev     <= 1'b0;
            last_vld    <= 1'b0;
            last_word   <= 1'b0;
            last_addr   <= '0;
            pend_vld    <= 1'b0;
            pend        <= '0;
            tmo_cnt     <= '0;
            MEM_REQ     <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WE      <= 1'b0;
            MEM_BE      <= '0;
            MEM_WDATA   <= '0;
            ROM_Q       <= '0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
`ifdef ROM_LAST_WORD_CACHE_EN
            cache_vld   <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
`endif
        end else begin
            state       <= state_d;
            rd_prev     <= rd_act;
            wr_prev     <= wr_act;
            last_vld    <= last_vld_d;
            last_word   <= last_word_d;
            last_addr   <= last_addr_d;
            pend_vld    <= pend_vld_d;
            pend        <= pend_d;
            tmo_cnt     <= tmo_cnt_d;
            MEM_REQ     <= mem_req_d;
            MEM_ADDR    <= mem_addr_d;
            MEM_WE      <= mem_we_d;
            MEM_BE      <= mem_be_d;
            MEM_WDATA   <= mem_wdata_d;
            ROM_Q       <= rom_q_d;
            BUSY        <= busy_d;
            TIMEOUT_ERR <= tmo_err_d;
`ifdef ROM_LAST_WORD_CACHE_EN
            cache_vld   <= cache_vld_d;
            cache_tag   <= cache_tag_d;
            cache_data  <= cache_data_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        last_vld_d  = last_vld;
        last_word_d = last_word;
        last_addr_d = last_addr;
        pend_vld_d  = pend_vld;
        pend_d      = pend;
        tmo_cnt_d   = tmo_cnt;
        mem_addr_d  = MEM_ADDR;
        mem_we_d    = MEM_WE;
        mem_be_d    = MEM_BE;
        mem_wdata_d = MEM_WDATA;
        rom_q_d     = ROM_Q;
        tmo_err_d   = TIMEOUT_ERR;
        issue       = 1'b0;
        issue_acc   = cur;
`ifdef ROM_LAST_WORD_CACHE_EN
        cache_vld_d  = cache_vld;
        cache_tag_d  = cache_tag;
        cache_data_d = cache_data;
`endif

        if (rd_trig) begin
            last_vld_d  = 1'b1;
            last_word_d = ROM_WORD;
            last_addr_d = ROM_ADDR;
        end

        // A pending write is never displaced; anything else takes the slot
        if (state != S_IDLE && trig && !(pend_vld && pend.wr)) begin
            pend_vld_d = 1'b1;
            pend_d     = cur;
        end

        case (state)
            S_IDLE: begin
                if (pend_vld) begin
                    issue      = 1'b1;
                    issue_acc  = pend;
                    pend_vld_d = trig;
                    pend_d     = cur;
                end else if (trig) begin
`ifdef ROM_LAST_WORD_CACHE_EN
                    if (rd_trig && hit)
                        rom_q_d = read_q(cache_data, be_of(cur));
                    else
                        issue = 1'b1;
`else
                    issue = 1'b1;
`endif
                end
            end
            S_REQ: begin
                state_d   = S_WAIT;
                tmo_cnt_d = '0;
            end
            S_WAIT: begin
                if (MEM_ACK) begin
                    state_d = S_IDLE;
                    if (!MEM_WE) begin
                        rom_q_d = read_q(MEM_RDATA, MEM_BE);
`ifdef ROM_LAST_WORD_CACHE_EN
                        cache_vld_d  = 1'b1;
                        cache_tag_d  = MEM_ADDR;
                        cache_data_d = MEM_RDATA;
`endif
                    end
                end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                    state_d   = S_IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            state_d     = S_REQ;
            mem_addr_d  = {issue_acc.addr[ADDR_W-1:1], 1'b0};
            mem_we_d    = issue_acc.wr;
            mem_be_d    = be_of(issue_acc);
            mem_wdata_d = wdata_of(issue_acc);
`ifdef ROM_LAST_WORD_CACHE_EN
            // Keep the cached word coherent with writes to it
            if (issue_acc.wr && cache_vld && cache_tag == {issue_acc.addr[ADDR_W-1:1], 1'b0}) begin
                if (mem_be_d[0]) cache_data_d[7:0]  = mem_wdata_d[7:0];
                if (mem_be_d[1]) cache_data_d[15:8] = mem_wdata_d[15:8];
            end
`endif
        end

        mem_req_d = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE) || pend_vld_d;
    end
endmodule

// File: tb/tb_rom_mem_bridge.sv
// Directed self-checking bench for rom_mem_bridge: vector table plus multi-cycle corner sequences.
module tb_rom_mem_bridge;
    logic        MCLK, RESET;
    logic [23:0] ROM_ADDR;
    logic [15:0] ROM_D;
    logic        ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_WORD;
    logic [15:0] ROM_Q;
    logic        MEM_REQ, MEM_WE, MEM_ACK, BUSY, TIMEOUT_ERR;
    logic [23:0] MEM_ADDR;
    logic [1:0]  MEM_BE;
    logic [15:0] MEM_WDATA, MEM_RDATA;

    rom_mem_bridge #(.ADDR_W(24), .ACK_TIMEOUT(8)) dut (
        .MCLK(MCLK), .RESET(RESET), .ROM_ADDR(ROM_ADDR), .ROM_D(ROM_D),
        .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N), .ROM_WE_N(ROM_WE_N), .ROM_WORD(ROM_WORD),
        .ROM_Q(ROM_Q), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
        .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic        word;
        logic [15:0] d;
        logic [15:0] rdata;
        logic [23:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic release_strobes();
        ROM_CE_N = 1'b1;
        ROM_OE_N = 1'b1;
        ROM_WE_N = 1'b1;
        step();
        step();
    endtask

    initial begin
        int          n_txn, wcnt, cnt;
        logic        acked, seen12;
        logic [23:0] cap_addr;
        logic [1:0]  cap_be;
        logic        cap_we;
        logic [15:0] cap_wdata;

        vecs[0] = '{1'b0, 24'h000100, 1'b1, 16'h0000, 16'hBEEF, 24'h000100, 2'b11, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b0, 24'h000402, 1'b0, 16'h0000, 16'h7766, 24'h000402, 2'b01, 16'h0000, 16'h0066};
        vecs[2] = '{1'b0, 24'h000101, 1'b0, 16'h0000, 16'h12AB, 24'h000100, 2'b10, 16'h0000, 16'h0012};
        vecs[3] = '{1'b1, 24'h000203, 1'b0, 16'h0055, 16'hFFFF, 24'h000202, 2'b10, 16'h5555, 16'h0012};
        vecs[4] = '{1'b1, 24'h000400, 1'b1, 16'hA5C3, 16'hFFFF, 24'h000400, 2'b11, 16'hA5C3, 16'h0012};

        MCLK = 1'b0; RESET = 1'b1;
        ROM_ADDR = '0; ROM_D = '0; ROM_WORD = 1'b0;
        ROM_CE_N = 1'b1; ROM_OE_N = 1'b1; ROM_WE_N = 1'b1;
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        step(); step();
        chk("rst_req",   32'(MEM_REQ),     32'd0);
        chk("rst_addr",  32'(MEM_ADDR),    32'd0);
        chk("rst_we",    32'(MEM_WE),      32'd0);
        chk("rst_be",    32'(MEM_BE),      32'd0);
        chk("rst_wdata", 32'(MEM_WDATA),   32'd0);
        chk("rst_q",     32'(ROM_Q),       32'd0);
        chk("rst_busy",  32'(BUSY),        32'd0);
        chk("rst_tmo",   32'(TIMEOUT_ERR), 32'd0);
        RESET = 1'b0;
        step();

        // Table: one access per vector, strobe held 14 cycles, memory acks 4 cycles into REQ
        for (int i = 0; i < 5; i++) begin
            ROM_ADDR = vecs[i].addr; ROM_WORD = vecs[i].word; ROM_D = vecs[i].d;
            ROM_CE_N = 1'b0; ROM_OE_N = vecs[i].wr; ROM_WE_N = ~vecs[i].wr;
            n_txn = 0; wcnt = 0; acked = 1'b0;
            cap_addr = '0; cap_be = '0; cap_we = 1'b0; cap_wdata = '0;
            for (int c = 0; c < 14; c++) begin
                step();
                MEM_ACK = 1'b0;
                if (acked) begin
                    chk($sformatf("v%0d_req_drop", i), 32'(MEM_REQ), 32'd0);
                    chk($sformatf("v%0d_q_after_ack", i), 32'(ROM_Q), 32'(vecs[i].exp_q));
                    acked = 1'b0;
                end
                if (MEM_REQ) begin
                    if (wcnt == 0) begin
                        n_txn++;
                        cap_addr = MEM_ADDR; cap_be = MEM_BE; cap_we = MEM_WE; cap_wdata = MEM_WDATA;
                    end
                    wcnt++;
                    if (wcnt == 4) begin
                        MEM_ACK = 1'b1; MEM_RDATA = vecs[i].rdata; wcnt = 0; acked = 1'b1;
                    end
                end
            end
            MEM_ACK = 1'b0;
            release_strobes();
            chk($sformatf("v%0d_txn_count", i), 32'(n_txn), 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(cap_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_be", i), 32'(cap_be), 32'(vecs[i].exp_be));
            chk($sformatf("v%0d_we", i), 32'(cap_we), 32'(vecs[i].wr));
            if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), 32'(cap_wdata), 32'(vecs[i].exp_wdata));
            chk($sformatf("v%0d_q_hold", i), 32'(ROM_Q), 32'(vecs[i].exp_q));
            chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'd0);
        end

        // Back-to-back: 0x10 issued, 0x12 replaced in the pending slot by 0x14
        seen12 = 1'b0;
        ROM_ADDR = 24'h10; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        step();
        chk("b2b_req0", 32'(MEM_REQ), 32'd1);
        chk("b2b_addr0", 32'(MEM_ADDR), 32'h10);
        ROM_ADDR = 24'h12; step();
        ROM_ADDR = 24'h14; step();
        step();
        MEM_ACK = 1'b1; MEM_RDATA = 16'h1111; step(); MEM_ACK = 1'b0;
        chk("b2b_req_drop0", 32'(MEM_REQ), 32'd0);
        chk("b2b_busy_pend", 32'(BUSY), 32'd1);
        chk("b2b_q0", 32'(ROM_Q), 32'h1111);
        step();
        chk("b2b_req1", 32'(MEM_REQ), 32'd1);
        chk("b2b_addr1", 32'(MEM_ADDR), 32'h14);
        for (int c = 0; c < 3; c++) begin
            step();
            if (MEM_ADDR == 24'h12) seen12 = 1'b1;
        end
        MEM_ACK = 1'b1; MEM_RDATA = 16'h2222; step(); MEM_ACK = 1'b0;
        chk("b2b_busy_done", 32'(BUSY), 32'd0);
        chk("b2b_q1", 32'(ROM_Q), 32'h2222);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (MEM_REQ) cnt++;
            if (MEM_ADDR == 24'h12) seen12 = 1'b1;
        end
        chk("b2b_no_extra_req", 32'(cnt), 32'd0);
        chk("b2b_0x12_dropped", 32'(seen12), 32'd0);
        release_strobes();

        // Timeout: no ACK, REQ high for 1 REQ + 8 WAIT cycles
        ROM_ADDR = 24'h000800; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c == 0) chk("tmo_err_pre", 32'(TIMEOUT_ERR), 32'd0);
            if (MEM_REQ) cnt++;
            else if (cnt > 0) break;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'd9);
        chk("tmo_req_low", 32'(MEM_REQ), 32'd0);
        chk("tmo_err_set", 32'(TIMEOUT_ERR), 32'd1);
        chk("tmo_q_hold", 32'(ROM_Q), 32'h2222);
        release_strobes();
        chk("tmo_busy", 32'(BUSY), 32'd0);
        chk("tmo_err_sticky", 32'(TIMEOUT_ERR), 32'd1);

        // Reset during WAIT followed by a stray ACK
        ROM_ADDR = 24'h000900; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        step(); step();
        chk("rstw_req_pre", 32'(MEM_REQ), 32'd1);
        RESET = 1'b1; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
        step();
        chk("rstw_req", 32'(MEM_REQ), 32'd0);
        chk("rstw_tmo_clr", 32'(TIMEOUT_ERR), 32'd0);
        chk("rstw_q", 32'(ROM_Q), 32'd0);
        RESET = 1'b0;
        MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD; step(); MEM_ACK = 1'b0;
        step();
        chk("stray_ack_q", 32'(ROM_Q), 32'd0);
        chk("stray_ack_req", 32'(MEM_REQ), 32'd0);
        chk("stray_ack_busy", 32'(BUSY), 32'd0);

`ifdef ROM_LAST_WORD_CACHE_EN
        // Fill the cache with 0x000100, then a re-read must not touch memory
        ROM_ADDR = 24'h000100; ROM_WORD = 1'b1; ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            MEM_ACK = 1'b0;
            if (MEM_REQ) begin
                wcnt++;
                if (wcnt == 3) begin MEM_ACK = 1'b1; MEM_RDATA = 16'hBEEF; end
            end
        end
        MEM_ACK = 1'b0;
        release_strobes();
        ROM_CE_N = 1'b0; ROM_OE_N = 1'b0;
        step();
        chk("cache_q", 32'(ROM_Q), 32'hBEEF);
        chk("cache_req0", 32'(MEM_REQ), 32'd0);
        step();
        chk("cache_req1", 32'(MEM_REQ), 32'd0);
        release_strobes();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_mem_bridge.md
Name: rom_mem_bridge

Overview:
- Sits directly downstream of the cartridge mapper mux. Consumes the muxed ROM_ADDR/ROM_D/ROM_CE_N/ROM_OE_N/ROM_WE_N/ROM_WORD strobes and returns ROM_Q.
- Converts the level-style chip-select interface into a single-outstanding req/ack transaction towards the SDRAM controller.
- Captures and holds read data for the mappers. Converts byte accesses to word-aligned accesses with byte enables.

Parameters:
- ADDR_W, 24, width of ROM_ADDR and MEM_ADDR.
- ACK_TIMEOUT, 255, cycles in WAIT without MEM_ACK before the request is abandoned (0 = never).

Ports:
- MCLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ROM_ADDR  in  ADDR_W  byte address from mapper mux.
- ROM_D  in  16  write data (BS-X flash writes).
- ROM_CE_N  in  1  chip enable, active low.
- ROM_OE_N  in  1  read strobe, active low.
- ROM_WE_N  in  1  write strobe, active low.
- ROM_WORD  in  1  1 = 16-bit access, 0 = 8-bit access.
- ROM_Q  out  16  read data to mappers, registered.
- MEM_REQ  out  1  request level to SDRAM controller.
- MEM_ADDR  out  ADDR_W  word-aligned address, bit 0 = 0.
- MEM_WE  out  1  1 = write transaction.
- MEM_BE  out  2  byte enables; [1] = high byte.
- MEM_WDATA  out  16  write data.
- MEM_ACK  in  1  one-cycle completion pulse.
- MEM_RDATA  in  16  read data, valid with MEM_ACK.
- BUSY  out  1  high whenever state is not IDLE or an access is pending.
- TIMEOUT_ERR  out  1  sticky; set on abandoned request; cleared by RESET.

Behaviour:
- Reset: while RESET is high, all outputs are 0, state is IDLE, pending slot is empty, last-issued record is cleared.
- Access detect (every cycle): ROM_CE_N=0 and (ROM_OE_N=0 or ROM_WE_N=0).
  - Read trigger: OE falling (registered prev), or {ADDR,WORD} differs from the last-issued read while OE is low.
  - Write trigger: WE falling only; exactly one write per WE_N assertion.
  - OE and WE both low: treated as write; read trigger suppressed.
- Request formation:
  - MEM_ADDR = {ROM_ADDR[ADDR_W-1:1],0}.
  - Word access: MEM_BE=11.
  - Byte access: MEM_BE = ROM_ADDR[0] ? 10 : 01; MEM_WDATA = {ROM_D[7:0],ROM_D[7:0]}.
  - Word write: MEM_WDATA = ROM_D.
- FSM:
  - IDLE: on trigger (or non-empty pending slot, which has priority), load MEM_* and go to REQ.
  - REQ: MEM_REQ=1; go to WAIT on the next cycle.
  - WAIT: MEM_REQ stays 1 until the cycle MEM_ACK=1. On ACK, MEM_REQ drops the next cycle, state returns to IDLE, and read data is latched.
  - A new request can issue at the earliest 1 cycle after returning to IDLE (min 3 cycles per transaction).
- MEM_ADDR/BE/WE/WDATA are stable from REQ entry until ACK.
- MEM_ACK received outside WAIT is ignored.
- Read data: on ACK for a read, the next cycle ROM_Q updates:
  - Word access: ROM_Q = MEM_RDATA.
  - Byte access: ROM_Q = {8'h00, addr0 ? RDATA[15:8] : RDATA[7:0]}.
  - ROM_Q holds otherwise, including across writes.
- Pending slot (1 deep): a trigger in REQ/WAIT is stored. A later read trigger overwrites a pending read. A pending write is never overwritten; further triggers while a write is pending are dropped.
- Timeout: with ACK_TIMEOUT≠0, an 8-bit counter runs in WAIT. At ACK_TIMEOUT cycles, MEM_REQ drops, TIMEOUT_ERR sets, state returns to IDLE, and ROM_Q is unchanged.
- RESET mid-transaction: MEM_REQ is 0 on the next edge; an ACK that arrives late is ignored.

Optional Feature:
- Macro: ROM_LAST_WORD_CACHE_EN.
- Defined:
  - A one-entry tag (MEM_ADDR, valid) and 16-bit data register are kept.
  - A read trigger whose word address equals the valid tag skips REQ/WAIT and updates ROM_Q the next cycle (1-cycle latency, MEM_REQ stays 0).
  - Any write to the same word address updates the cached bytes per MEM_BE.
  - RESET invalidates the entry.
- Undefined: every read issues a memory transaction; no tag logic is present.

Test Plan:
- Word read: ADDR=0x000100, WORD=1, CE/OE low; ACK 4 cycles after REQ with RDATA=0xBEEF -> MEM_ADDR=0x000100, BE=11, ROM_Q=0xBEEF one cycle after ACK, REQ low after ACK.
- Byte read odd: ADDR=0x000101, WORD=0, RDATA=0x12AB -> BE=10, ROM_Q=0x0012.
- Byte write: ADDR=0x000203, D=0x0055, WE pulse low for 10 cycles -> exactly one transaction, WE=1, BE=10, WDATA=0x5555. ROM_Q unchanged.
- Back-to-back: address changes 0x10→0x12→0x14 during WAIT of the first read -> 0x10 then 0x14 issued, 0x12 dropped, BUSY low only after 0x14 ACK.
- Timeout/reset: ACK_TIMEOUT=8, no ACK -> REQ drops after 8 WAIT cycles, TIMEOUT_ERR=1. Separately, RESET during WAIT then a stray ACK -> no ROM_Q update, state IDLE.
- With ROM_LAST_WORD_CACHE_EN: re-read 0x000100 after the first test -> MEM_REQ stays 0, ROM_Q=0xBEEF next cycle.
